// File: rtl/fd_pkg.sv
// Shared constants, FSM state type and ring-offset table for the
// feature-detect ring fetcher.
package fd_pkg;

  localparam int IMG_W  = 180;
  localparam int RING_N = 16;
  localparam int NPIX   = RING_N + 1;   // center + ring
  localparam int IDX_W  = 5;            // holds 0..NPIX

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fd_state_t;

  // Word offsets from the center pixel: index 0 is the center, 1..16 walk
  // the radius-3 Bresenham circle clockwise starting straight above.
  localparam int RING_OFS [0:NPIX-1] = '{
    0,
    -3*IMG_W,     -3*IMG_W + 1, -2*IMG_W + 2, -IMG_W + 3,
    3,            IMG_W + 3,    2*IMG_W + 2,  3*IMG_W + 1,
    3*IMG_W,      3*IMG_W - 1,  2*IMG_W - 2,  IMG_W - 3,
    -3,           -IMG_W - 3,   -2*IMG_W - 2, -3*IMG_W - 1
  };

  // Table lookup guarded against indices past the last entry.
  function automatic int ring_offset(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(NPIX)) return RING_OFS[idx];
    return 0;
  endfunction

endpackage

// File: rtl/fd_ring_fetch_if.sv
// SRAM read-port bundle between the ring fetcher (master) and the
// SRAM read arbiter (slave).
interface fd_ring_fetch_if
  import fd_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 8
);
  logic              srmRd;
  logic [ADDR_W-1:0] srmAddr;
  logic              srmGrant;
  logic              srmRdValid;
  logic [PIX_W-1:0]  srmRdData;

  modport master (
    output srmRd, srmAddr,
    input  srmGrant, srmRdValid, srmRdData
  );

  modport slave (
    input  srmRd, srmAddr,
    output srmGrant, srmRdValid, srmRdData
  );
endinterface

// File: rtl/fd_ring_bank.sv
// 17-entry pixel capture bank. Returned pixels land at the write pointer,
// which advances per write and is rewound at the start of each fetch.
// Entry contents survive the rewind so the last complete set stays visible.
module fd_ring_bank
  import fd_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [PIX_W-1:0]        wr_data,
  output logic [IDX_W-1:0]        wr_ptr,
  output logic [NPIX*PIX_W-1:0]   pix
);

  logic [IDX_W-1:0] ptr_reg;

  assign wr_ptr = ptr_reg;

  // Write pointer: rewind on clear, advance per write, saturate at NPIX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (wr_en && (ptr_reg < IDX_W'(NPIX))) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_entry
      logic [PIX_W-1:0] entry_reg;

      // One entry: loads when the pointer selects it.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          entry_reg <= '0;
        end else if (wr_en && !clr && (ptr_reg == IDX_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign pix[gi*PIX_W +: PIX_W] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/fd_ring_fetch.sv
// Ring fetch sequencer: issues the 17 neighbourhood reads for one
// reference pixel, collects the in-order returns into the capture bank and
// pulses done once the whole set is present.
module fd_ring_fetch
  import fd_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         refAddr,
  output logic                      busy,
  output logic                      done,
  fd_ring_fetch_if.master           srm,
  output logic [PIX_W-1:0]          centerPix,
  output logic [RING_N*PIX_W-1:0]   ringPix
);

  // Returns are counted rather than timed, so the latency only has to be
  // in the supported range.
  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_check
      $error("fd_ring_fetch: RD_LAT must be within 1..4");
    end
  endgenerate

  fd_state_t            state_reg, state_next;
  logic [IDX_W-1:0]     issue_idx_reg, issue_idx_next;
  logic [ADDR_W-1:0]    base_reg, base_next;

  logic [IDX_W-1:0]       cap_ptr;
  logic [NPIX*PIX_W-1:0]  bank_pix;
  logic                   fetch_go;
  logic                   accept;
  logic                   cap_en;
  logic                   cap_last;

  assign fetch_go = (state_reg == ST_IDLE) && start;
  assign accept   = (state_reg == ST_ISSUE) && srm.srmGrant;
  assign cap_en   = ((state_reg == ST_ISSUE) || (state_reg == ST_DRAIN)) && srm.srmRdValid;
  assign cap_last = cap_en && (cap_ptr == IDX_W'(NPIX - 1));

  // Next-state logic: step through the offsets on each accepted read,
  // then wait for the final return before signalling completion.
  always_comb begin
    state_next     = state_reg;
    issue_idx_next = issue_idx_reg;
    base_next      = base_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          base_next      = refAddr;
          issue_idx_next = '0;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          if (issue_idx_reg == IDX_W'(RING_N)) begin
            state_next = ST_DRAIN;
          end else begin
            issue_idx_next = issue_idx_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Jump on the last capture itself so done lands the cycle after it.
        if (cap_last || (cap_ptr == IDX_W'(NPIX))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, issue index and latched reference address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      issue_idx_reg <= '0;
      base_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      issue_idx_reg <= issue_idx_next;
      base_reg      <= base_next;
    end
  end

  // Address is a pure function of registered state, so it holds steady
  // through grant stalls. Arithmetic wraps modulo 2^ADDR_W by truncation.
  assign srm.srmRd   = (state_reg == ST_ISSUE);
  assign srm.srmAddr = (state_reg == ST_ISSUE)
                       ? base_reg + ADDR_W'(ring_offset(issue_idx_reg))
                       : '0;

  assign busy = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
  assign done = (state_reg == ST_DONE);

  fd_ring_bank #(.PIX_W(PIX_W)) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (fetch_go),
    .wr_en   (cap_en),
    .wr_data (srm.srmRdData),
    .wr_ptr  (cap_ptr),
    .pix     (bank_pix)
  );

  assign centerPix = bank_pix[PIX_W-1:0];
  assign ringPix   = bank_pix[NPIX*PIX_W-1:PIX_W];

endmodule

// File: tb/tb_fd_ring_fetch.sv
// Bench for fd_ring_fetch: two instances (RD_LAT 2 and 4) share stimulus;
// a transaction-level model per instance predicts every output each cycle.
module tb_fd_ring_fetch;
  localparam int AW = 15;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          start;
  logic          grant;
  logic [AW-1:0] ref_addr;

  logic          rv   [2] = '{1'b0, 1'b0};
  logic [PW-1:0] rdat [2] = '{8'h00, 8'h00};
  logic          dbusy [2];
  logic          ddone [2];
  logic          drd   [2];
  logic [AW-1:0] daddr [2];
  logic [PW-1:0] dcpix [2];
  logic [16*PW-1:0] drpix [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      fd_ring_fetch_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();
      assign bus.srmGrant   = grant;
      assign bus.srmRdValid = rv[gi];
      assign bus.srmRdData  = rdat[gi];
      assign drd[gi]   = bus.srmRd;
      assign daddr[gi] = bus.srmAddr;

      fd_ring_fetch #(.ADDR_W(AW), .PIX_W(PW), .RD_LAT(gi == 0 ? 2 : 4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .refAddr   (ref_addr),
        .busy      (dbusy[gi]),
        .done      (ddone[gi]),
        .srm       (bus),
        .centerPix (dcpix[gi]),
        .ringPix   (drpix[gi])
      );
    end
  endgenerate

  // Geometry of the test neighbourhood, written out independently.
  int ofs [17] = '{0, -540, -539, -358, -177, 3, 183, 362, 541,
                   540, 539, 358, 177, -3, -183, -362, -541};
  int t1_addr [17] = '{1000, 460, 461, 642, 823, 1003, 1183, 1362, 1541,
                       1540, 1539, 1358, 1177, 997, 817, 638, 459};

  // Model state per instance.
  bit        m_active [2];
  bit        m_done   [2];
  int        m_issued [2];
  int        m_cap    [2];
  int        m_base   [2];
  logic [7:0] m_bank  [2][17];
  logic       pend_v  [2][8] = '{default: 1'b0};
  logic [7:0] pend_d  [2][8] = '{default: 8'h00};
  int        start_cyc [2];
  int        n_acc     [2];
  int        hold      [2];
  int        acc_addr  [2][17];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tmo = 0;
  int   test_id = 0;
  int   rst_cyc = -100;
  logic [7:0] salt = 8'h00;
  bit   fin_req = 1'b0;

  function automatic int lat_of(input int l);
    return (l == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int lane,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got %0h expected %0h", name, lane, act, exp);
    end
  endtask

  // Compare process: check outputs, play the SRAM, then advance the model.
  always @(negedge clk) begin
    logic [127:0] er;
    int slot;
    int lat;
    cyc++;
    if (fin_req) begin
      chk("timeouts", 0, 128'(tmo), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    if (!resetn && test_id == 5) rst_cyc = cyc;
    for (int l = 0; l < 2; l++) begin
      if (!resetn) begin
        m_active[l] = 1'b0;
        m_done[l]   = 1'b0;
        m_issued[l] = 0;
        m_cap[l]    = 0;
        for (int k = 0; k < 17; k++) m_bank[l][k] = 8'h00;
      end

      chk("busy", l, 128'(dbusy[l]), 128'(m_active[l]));
      chk("done", l, 128'(ddone[l]), 128'(m_done[l]));
      chk("srmRd", l, 128'(drd[l]), 128'(m_active[l] && m_issued[l] < 17));
      if (m_active[l] && m_issued[l] < 17)
        chk("srmAddr", l, 128'(daddr[l]),
            128'((m_base[l] + ofs[m_issued[l]]) & 32'h7FFF));
      er = '0;
      for (int k = 1; k < 17; k++) er[(k-1)*8 +: 8] = m_bank[l][k];
      chk("centerPix", l, 128'(dcpix[l]), 128'(m_bank[l][0]));
      chk("ringPix", l, 128'(drpix[l]), er);

      // Hand-computed expectations.
      if (!resetn && test_id == 5) begin
        chk("rst_center", l, 128'(dcpix[l]), 128'd0);
        chk("rst_srmRd", l, 128'(drd[l]), 128'd0);
        chk("rst_ring", l, 128'(drpix[l]), 128'd0);
      end
      if (resetn && test_id == 5 && cyc == rst_cyc + 6)
        chk("stray_center", l, 128'(dcpix[l]), 128'd0);
      if (m_done[l]) begin
        $display("fetch lane%0d test%0d ref=%0d lat=%0d reads=%0d center=%02h",
                 l, test_id, m_base[l], cyc - start_cyc[l], n_acc[l], dcpix[l]);
        case (test_id)
          1: begin
            chk("t1_latency", l, 128'(cyc - start_cyc[l]), 128'(l == 0 ? 20 : 22));
            for (int k = 0; k < 17; k++)
              chk("t1_addr", l, 128'(acc_addr[l][k]), 128'(t1_addr[k]));
            chk("t1_center", l, 128'(dcpix[l]), 128'hE8);
            chk("t1_ring1", l, 128'(drpix[l][7:0]), 128'hCC);
          end
          2: begin
            chk("t2_idx1", l, 128'(acc_addr[l][1]), 128'd32328);
            chk("t2_idx16", l, 128'(acc_addr[l][16]), 128'd32327);
            chk("t2_idx8", l, 128'(acc_addr[l][8]), 128'd641);
          end
          3: begin
            chk("t3_latency", l, 128'(cyc - start_cyc[l]), 128'(l == 0 ? 23 : 25));
            chk("t3_hold", l, 128'(hold[l]), 128'd4);
            chk("t3_reads", l, 128'(n_acc[l]), 128'd17);
          end
          4: chk("t4_reads", l, 128'(n_acc[l]), 128'd17);
          5: begin
            chk("t5_latency", l, 128'(cyc - start_cyc[l]), 128'(l == 0 ? 20 : 22));
            chk("t5_center", l, 128'(dcpix[l]), 128'hD0);
          end
          default: ;
        endcase
      end

      // SRAM returns scheduled for this cycle.
      slot = cyc % 8;
      rv[l]   = pend_v[l][slot];
      rdat[l] = pend_d[l][slot];
      pend_v[l][slot] = 1'b0;

      if (resetn) begin
        if (m_done[l]) begin
          m_done[l] = 1'b0;
        end else if (!m_active[l]) begin
          if (start) begin
            m_active[l] = 1'b1;
            m_issued[l] = 0;
            m_cap[l]    = 0;
            m_base[l]   = int'(ref_addr);
            start_cyc[l] = cyc;
            n_acc[l]    = 0;
            hold[l]     = 0;
          end
        end else begin
          if (m_issued[l] < 17 && grant) m_issued[l]++;
          if (rv[l] && m_cap[l] < 17) begin
            m_bank[l][m_cap[l]] = rdat[l];
            m_cap[l]++;
            if (m_cap[l] == 17) begin
              m_active[l] = 1'b0;
              m_done[l]   = 1'b1;
            end
          end
        end
        if (drd[l] && grant) begin
          lat = lat_of(l);
          slot = (cyc + lat) % 8;
          pend_v[l][slot] = 1'b1;
          pend_d[l][slot] = daddr[l][7:0] ^ salt;
          if (n_acc[l] < 17) acc_addr[l][n_acc[l]] = int'(daddr[l]);
          n_acc[l]++;
        end
        if (test_id == 3 && drd[l] && daddr[l] == AW'(1003)) hold[l]++;
      end
    end
  end

  task automatic do_start(input int a);
    @(posedge clk); #1;
    start = 1'b1;
    ref_addr = AW'(a);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_active[0] || m_active[1] || m_done[0] || m_done[1]) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= bound) tmo++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int rst_at;
    bit rst_this;
    int n;
    resetn = 1'b0;
    start = 1'b0;
    grant = 1'b1;
    ref_addr = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    test_id = 1; do_start(1000); wait_idle(100);
    test_id = 2; do_start(100);  wait_idle(100);

    test_id = 3; do_start(1000);
    repeat (5) @(posedge clk); #1 grant = 1'b0;
    repeat (3) @(posedge clk); #1 grant = 1'b1;
    wait_idle(100);

    test_id = 4; do_start(1000);
    repeat (4) @(posedge clk); #1 start = 1'b1; ref_addr = AW'(5000);
    @(posedge clk); #1 start = 1'b0;
    wait_idle(100);

    test_id = 5; do_start(1000);
    repeat (9) @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (8) @(posedge clk);
    do_start(2000);
    wait_idle(100);

    test_id = 9;
    for (int f = 0; f < 40; f++) begin
      salt = 8'($urandom);
      rst_this = ($urandom_range(0, 5) == 0);
      rst_at = $urandom_range(1, 25);
      do_start(int'($urandom_range(0, 32767)));
      n = 0;
      while ((m_active[0] || m_active[1] || m_done[0] || m_done[1]) && n < 400) begin
        @(posedge clk); #1;
        grant = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        ref_addr = AW'($urandom);
        resetn = !(rst_this && n == rst_at);
        n++;
      end
      if (n >= 400) tmo++;
      grant = 1'b1;
      start = 1'b0;
      resetn = 1'b1;
      repeat (6) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    fin_req = 1'b1;
  end

endmodule

// File: doc/fd_ring_fetch.md
Name: fd_ring_fetch

Overview:
- Read-side sequencer for the feature-detect pipeline. Takes one reference pixel address and fetches the 17-pixel test neighbourhood from frame SRAM: the center pixel plus the 16 pixels of a radius-3 Bresenham ring, image width 180.
- Captures the returned pixels into a register bank and presents them in parallel to the corner-score logic.
- Sits between the detect-control FSM (upstream) and the SRAM read arbiter (downstream).

Parameters:
- ADDR_W, 15, SRAM word-address width; all address arithmetic is modulo 2^ADDR_W.
- PIX_W, 8, pixel width (grayscale).
- RD_LAT, 2, fixed cycles from an accepted read to its srmRdValid; legal range 1..4.

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- refAddr  in  ADDR_W  center pixel address; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all 17 pixels are captured.
- srmRd  out  1  read request.
- srmAddr  out  ADDR_W  read address; valid while srmRd=1.
- srmGrant  in  1  arbiter accept; a read is accepted in a cycle where srmRd=1 and srmGrant=1.
- srmRdValid  in  1  read data valid; returns in issue order, exactly RD_LAT cycles after acceptance.
- srmRdData  in  PIX_W  read data.
- centerPix  out  PIX_W  pixel index 0.
- ringPix  out  16*PIX_W  ring pixels; index k (1..16) occupies bits [k*PIX_W-1 : (k-1)*PIX_W].

Behaviour:
- Offsets, index 0..16:
  - 0: +0
  - 1–4: −540, −539, −358, −177
  - 5–8: +3, +183, +362, +541
  - 9–12: +540, +539, +358, +177
  - 13–16: −3, −183, −362, −541
- srmAddr = (latched refAddr + offset[idx]) mod 2^ADDR_W. No bounds check: wrap is intended, and the caller guarantees a 3-pixel border.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 latches refAddr, clears issue index and capture index to 0, goes to ISSUE. busy rises next cycle.
  - ISSUE: srmRd=1 with srmAddr for the current issue index.
    - On accept, the issue index increments.
    - Without grant, srmRd and srmAddr hold stable; the index does not advance.
    - The accept of index 16 moves the FSM to DRAIN, and srmRd drops the next cycle.
  - DRAIN: wait until the capture index reaches 17, then go to DONE.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Capture: each srmRdValid writes srmRdData to the bank entry at the capture index, then increments it. This runs in ISSUE and DRAIN.
- srmRdValid in IDLE or DONE is ignored.
- Output hold: centerPix and ringPix are register outputs. They hold the last completed set until overwritten by the next fetch. Partial updates during a fetch are visible, so consumers sample only on done.
- start while busy: ignored, with no queueing.
- Reset values: busy=0, done=0, srmRd=0, srmAddr=0, centerPix=0, ringPix=0, FSM=IDLE.
- Reset mid-operation: immediate return to IDLE with the bank cleared. In-flight returns arriving after deassertion are ignored, because the FSM is in IDLE.
- Latency with srmGrant tied high: start sampled at cycle 0, reads at cycles 1..17, last data at 17+RD_LAT, done at 18+RD_LAT (20 at default).

Decomposition:
- Shared package fd_pkg:
  - IMG_W=180 and RING_N=16.
  - The 17-entry signed offset table, as constants.
  - An FSM state enum.
- One sub-module, fd_ring_bank: the 17×PIX_W capture register bank with its write pointer and clear. It keeps the top-level module to the FSM and address generation.

Test Plan:
1. refAddr=1000, srmGrant=1, memory returns addr[7:0], RD_LAT=2:
   - srmAddr sequence is 1000, 460, 461, 642, 823, 1003, 1183, 1362, 1541, 1540, 1539, 1358, 1177, 997, 817, 638, 459.
   - done at cycle 20.
   - centerPix=0xE8; ring index 1 =0xCC.
2. Wrap: refAddr=100 → index-1 srmAddr=32328, index-16 srmAddr=32327; index-8 srmAddr=641.
3. Grant stall: deassert srmGrant for 3 cycles at index 5 → srmAddr holds 1003 for 4 cycles, no index skipped, done at cycle 23.
4. start pulsed at cycle 5 while busy → ignored; exactly 17 reads issued; one done pulse.
5. resetn low at cycle 10 for 1 cycle → all outputs zero, srmRd=0; stray srmRdValid afterwards leaves centerPix=0; the next start completes normally.
6. RD_LAT=4 build, same as test 1 → done at cycle 22, identical captured data.
